// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line memory port between the I-cache and the D-cache.
// Memory strobes are registered; completion pulses are routed combinationally from mem_ready.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no transaction in flight, arbitrating i_req / d_req
// GNT_I | I-cache owns the memory port until mem_ready
// GNT_D | D-cache owns the memory port until mem_ready
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int LINE_W = 128,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [CNT_W-1:0]  stat_conflict,
   output logic [CNT_W-1:0]  stat_wait
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t state;
   logic   last_d;
   logic   i_req;
   logic   d_req;
   logic   pick_d;
   logic   conflict_hit;
   logic   wait_hit;

   assign i_req = i_read | i_write;
   assign d_req = d_read | d_write;

   // On contention the side that was not served last wins.
   assign pick_d = d_req & (~i_req | ~last_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_d    <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_d) begin
                  state     <= GNT_D;
                  last_d    <= 1'b1;
                  mem_read  <= d_read;
                  mem_write <= d_write;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
               end else if (i_req) begin
                  state     <= GNT_I;
                  last_d    <= 1'b0;
                  mem_read  <= i_read;
                  mem_write <= i_write;
                  mem_addr  <= i_addr;
                  mem_wdata <= i_wdata;
               end
            end
            GNT_I, GNT_D: begin
               if (mem_ready) begin
                  state     <= IDLE;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
            end
         endcase
      end
   end

   assign i_ready = (state == GNT_I) & mem_ready;
   assign d_ready = (state == GNT_D) & mem_ready;
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   // A pending side counts as waiting in every cycle it does not own the port, including IDLE.
   assign conflict_hit = (state == IDLE) & i_req & d_req;
   assign wait_hit     = (i_req & (state != GNT_I)) | (d_req & (state != GNT_D));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_conflict <= '0;
         stat_wait     <= '0;
      end else begin
         if (conflict_hit && (stat_conflict != CNT_MAX)) begin
            stat_conflict <= stat_conflict + CNT_ONE;
         end
         if (wait_hit && (stat_wait != CNT_MAX)) begin
            stat_wait <= stat_wait + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a latency-programmable memory responder.
module tb_mem_arbiter;
   localparam int AW = 28;
   localparam int LW = 128;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_read = 1'b0, i_write = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [LW-1:0] i_wdata = '0;
   logic [LW-1:0] i_rdata;
   logic          i_ready;
   logic          d_read = 1'b0, d_write = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [LW-1:0] d_wdata = '0;
   logic [LW-1:0] d_rdata;
   logic          d_ready;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic [CW-1:0] stat_conflict, stat_wait;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stat_conflict(stat_conflict), .stat_wait(stat_wait)
   );

   function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
      return {4{{4'h0, a} ^ 32'h5A5A_C3C3}};
   endfunction

   // Memory responder: answers a held strobe after mem_lat cycles with a one-cycle pulse.
   int mem_lat = 2;
   bit mem_en = 1'b1;
   bit mem_spur = 1'b0;
   int mem_cnt = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n || mem_ready) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
            mem_rdata = {4{$urandom}};
         end else if (mem_spur) begin
            mem_ready = 1'b1;
            mem_spur  = 1'b0;
         end else if (mem_en && (mem_read || mem_write)) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
               mem_ready = 1'b1;
               mem_rdata = line_of(mem_addr);
            end
         end else begin
            mem_cnt = 0;
         end
      end
   end

   // Records every memory transaction the DUT starts, in order.
   logic [AW+1:0] obs_q[$];
   logic [LW-1:0] obs_wd[$];
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      if ((mem_read || mem_write) && !prev_busy) begin
         obs_q.push_back({mem_write, mem_read, mem_addr});
         obs_wd.push_back(mem_wdata);
      end
      prev_busy <= mem_read || mem_write;
   end

   // Reference model: owner 0=none 1=I 2=D; last side served; saturating statistics.
   int            m_owner, m_last, m_conf, m_wait;
   logic          m_rd, m_wr;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_wdata;

   function automatic int pick_side(input bit ir, input bit dr, input int last);
      if (ir && dr) return (last == 1) ? 2 : 1;
      if (dr) return 2;
      if (ir) return 1;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= 0; m_last <= 1; m_conf <= 0; m_wait <= 0;
         m_rd <= 1'b0; m_wr <= 1'b0; m_addr <= '0; m_wdata <= '0;
      end else begin
         if (m_owner == 0 && (i_read | i_write) && (d_read | d_write) && m_conf < 65535)
            m_conf <= m_conf + 1;
         if ((((i_read | i_write) && m_owner != 1) || ((d_read | d_write) && m_owner != 2))
             && m_wait < 65535)
            m_wait <= m_wait + 1;
         if (m_owner == 0) begin
            case (pick_side(i_read | i_write, d_read | d_write, m_last))
               1: begin
                  m_owner <= 1; m_last <= 1;
                  m_rd <= i_read; m_wr <= i_write; m_addr <= i_addr; m_wdata <= i_wdata;
               end
               2: begin
                  m_owner <= 2; m_last <= 2;
                  m_rd <= d_read; m_wr <= d_write; m_addr <= d_addr; m_wdata <= d_wdata;
               end
               default: ;
            endcase
         end else if (mem_ready) begin
            m_owner <= 0; m_rd <= 1'b0; m_wr <= 1'b0;
         end
      end
   end

   task automatic do_reset(input int cycles);
      @(negedge clk);
      i_read = 0; i_write = 0; d_read = 0; d_write = 0;
      rst_n = 1'b0;
      repeat (cycles) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Waits for a completion pulse; side: 0 timeout, 1 I, 2 D, 3 both.
   task automatic wait_ready(input int budget, output int side, output int cycles,
                             output logic [LW-1:0] data);
      side = 0; cycles = 0; data = '0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk); #3;
         if (i_ready || d_ready) begin
            side   = (i_ready ? 1 : 0) + (d_ready ? 2 : 0);
            data   = i_ready ? i_rdata : d_rdata;
            cycles = c;
            break;
         end
      end
   endtask

   task automatic test_reset;
      do_reset(2);
      #3;
      total++;
      if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0) begin
         bad++;
         $display("FAIL reset_strobes: got rd=%b wr=%b ir=%b dr=%b expected all 0",
                  mem_read, mem_write, i_ready, d_ready);
      end
      total++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         bad++;
         $display("FAIL reset_addr: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
      end
      total++;
      if (stat_conflict !== '0 || stat_wait !== '0) begin
         bad++;
         $display("FAIL reset_stats: got conflict=%0d wait=%0d expected 0", stat_conflict, stat_wait);
      end
   endtask

   task automatic test_single_read;
      int side, cyc;
      logic [LW-1:0] data;
      mem_lat = 4;
      @(negedge clk);
      i_read = 1; i_addr = 28'h0000010;
      @(posedge clk); #1;
      total++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000010) begin
         bad++;
         $display("FAIL t1_strobe: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=0000010",
                  mem_read, mem_write, mem_addr);
      end
      wait_ready(20, side, cyc, data);
      total++;
      if (side !== 1 || cyc !== 4) begin
         bad++;
         $display("FAIL t1_ready: got side=%0d after %0d cycles expected side=1 after 4", side, cyc);
      end
      total++;
      if (data !== line_of(28'h0000010)) begin
         bad++;
         $display("FAIL t1_rdata: got %h expected %h", data, line_of(28'h0000010));
      end
      @(negedge clk);
      i_read = 0;
      #3;
      total++;
      if (i_ready !== 1'b0 || d_ready !== 1'b0 || mem_read !== 1'b0) begin
         bad++;
         $display("FAIL t1_pulse_end: got ir=%b dr=%b rd=%b expected 0 0 0", i_ready, d_ready, mem_read);
      end
   endtask

   task automatic test_conflict;
      int side, cyc;
      logic [LW-1:0] data, wd;
      do_reset(1);
      mem_lat = 3;
      wd = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      i_read = 1; i_addr = 28'h0000A10;
      d_write = 1; d_addr = 28'h0000B20; d_wdata = wd;
      @(posedge clk); #1;
      total++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h0000B20 || mem_wdata !== wd) begin
         bad++;
         $display("FAIL t2_first_grant: got rd=%b wr=%b addr=%h expected D write addr=0000b20",
                  mem_read, mem_write, mem_addr);
      end
      total++;
      if (stat_conflict !== 16'd1) begin
         bad++;
         $display("FAIL t2_conflict: got %0d expected 1", stat_conflict);
      end
      wait_ready(20, side, cyc, data);
      total++;
      if (side !== 2) begin
         bad++;
         $display("FAIL t2_first_ready: got side=%0d expected 2", side);
      end
      @(negedge clk);
      d_write = 0;
      wait_ready(20, side, cyc, data);
      total++;
      if (side !== 1 || data !== line_of(28'h0000A10)) begin
         bad++;
         $display("FAIL t2_second_ready: got side=%0d data=%h expected side=1", side, data);
      end
      @(negedge clk);
      i_read = 0;
      #3;
      // I waits in the conflict cycle, mem_lat grant cycles, and one IDLE cycle.
      total++;
      if (stat_wait !== 16'(mem_lat + 2) || stat_conflict !== 16'd1) begin
         bad++;
         $display("FAIL t2_stats: got wait=%0d conflict=%0d expected wait=%0d conflict=1",
                  stat_wait, stat_conflict, mem_lat + 2);
      end
   endtask

   task automatic test_alternate;
      int side, cyc, exp_side;
      logic [LW-1:0] data;
      do_reset(1);
      @(negedge clk);
      i_read = 1; i_addr = 28'h0111110;
      d_read = 1; d_addr = 28'h0222220;
      for (int k = 0; k < 6; k++) begin
         mem_lat = $urandom_range(1, 5);
         exp_side = (k % 2 == 0) ? 2 : 1;
         wait_ready(30, side, cyc, data);
         total++;
         if (side !== exp_side ||
             data !== line_of(exp_side == 1 ? 28'h0111110 : 28'h0222220)) begin
            bad++;
            $display("FAIL t3_alternate[%0d]: got side=%0d data=%h expected side=%0d", k, side, data, exp_side);
         end
      end
      @(negedge clk);
      i_read = 0; d_read = 0;
   endtask

   task automatic test_writeback_refill;
      int side, cyc;
      logic [LW-1:0] data, wd;
      do_reset(1);
      mem_lat = 2;
      wd = {$urandom, $urandom, $urandom, $urandom};
      #3;
      obs_q.delete(); obs_wd.delete();
      @(negedge clk);
      d_write = 1; d_addr = 28'h1234567; d_wdata = wd;
      i_read = 1; i_addr = 28'h0000700;
      wait_ready(20, side, cyc, data);
      @(negedge clk);
      d_write = 0; d_read = 1;
      wait_ready(20, side, cyc, data);
      @(negedge clk);
      i_read = 0;
      wait_ready(20, side, cyc, data);
      total++;
      if (side !== 2 || data !== line_of(28'h1234567)) begin
         bad++;
         $display("FAIL t4_refill: got side=%0d data=%h expected side=2", side, data);
      end
      @(negedge clk);
      d_read = 0;
      #3;
      total++;
      if (obs_q.size() != 3) begin
         bad++;
         $display("FAIL t4_count: got %0d transactions expected 3", obs_q.size());
      end else if (obs_q[0] !== {2'b10, 28'h1234567} || obs_q[1] !== {2'b01, 28'h0000700} ||
                   obs_q[2] !== {2'b01, 28'h1234567} || obs_wd[0] !== wd) begin
         bad++;
         $display("FAIL t4_order: got %h %h %h expected W(D) R(I) R(D)", obs_q[0], obs_q[1], obs_q[2]);
      end
   endtask

   task automatic test_drop;
      int side, cyc;
      logic [LW-1:0] data;
      mem_lat = 3;
      @(negedge clk);
      i_read = 1; i_addr = 28'h0000C40;
      @(posedge clk); #1;
      @(negedge clk);
      i_read = 0;
      wait_ready(20, side, cyc, data);
      total++;
      if (side !== 1 || data !== line_of(28'h0000C40)) begin
         bad++;
         $display("FAIL drop_completes: got side=%0d expected 1", side);
      end
   endtask

   task automatic test_idle_ready;
      @(negedge clk); #3;
      mem_spur = 1'b1;
      @(negedge clk); #3;
      total++;
      if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
         bad++;
         $display("FAIL idle_ready: got ir=%b dr=%b expected 0 0 (mem_ready=%b)", i_ready, d_ready, mem_ready);
      end
      @(posedge clk); #1;
      total++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         bad++;
         $display("FAIL idle_ready_state: got rd=%b wr=%b expected 0 0", mem_read, mem_write);
      end
   endtask

   task automatic test_reset_mid;
      int side, cyc;
      logic [LW-1:0] data;
      mem_lat = 8;
      @(negedge clk);
      d_read = 1; d_addr = 28'h0ABCDEF;
      @(posedge clk); #1;
      total++;
      if (mem_read !== 1'b1 || mem_addr !== 28'h0ABCDEF) begin
         bad++;
         $display("FAIL t5_grant: got rd=%b addr=%h expected 1 0abcdef", mem_read, mem_addr);
      end
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0) begin
         bad++;
         $display("FAIL t5_async: got rd=%b wr=%b addr=%h expected 0 0 0", mem_read, mem_write, mem_addr);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (mem_read !== 1'b1 || mem_addr !== 28'h0ABCDEF || stat_conflict !== '0) begin
         bad++;
         $display("FAIL t5_regrant: got rd=%b addr=%h conflict=%0d expected 1 0abcdef 0",
                  mem_read, mem_addr, stat_conflict);
      end
      wait_ready(20, side, cyc, data);
      total++;
      if (side !== 2) begin
         bad++;
         $display("FAIL t5_ready: got side=%0d expected 2", side);
      end
      @(negedge clk);
      d_read = 0;
      mem_lat = 2;
   endtask

   task automatic test_random;
      bit i_busy, d_busy, i_done, d_done;
      int kind;
      i_busy = 0; d_busy = 0; i_done = 0; d_done = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         if (i_done) begin i_read = 0; i_write = 0; i_busy = 0; i_done = 0; end
         if (d_done) begin d_read = 0; d_write = 0; d_busy = 0; d_done = 0; end
         if (!i_busy && $urandom_range(0, 2) == 0) begin
            i_busy = 1; i_read = 1; i_write = ($urandom_range(0, 9) == 0);
            i_addr = AW'($urandom); i_wdata = {4{$urandom}};
         end
         if (!d_busy && $urandom_range(0, 2) == 0) begin
            kind = $urandom_range(0, 4);
            d_busy = 1; d_read = (kind < 2 || kind == 4); d_write = (kind >= 2);
            d_addr = AW'($urandom); d_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
         if ($urandom_range(0, 3) == 0) mem_lat = $urandom_range(1, 6);
         #3;
         total++;
         if ({mem_read, mem_write, mem_addr, mem_wdata} !== {m_rd, m_wr, m_addr, m_wdata}) begin
            bad++;
            $display("FAIL rnd_port[%0d]: got rd=%b wr=%b addr=%h expected rd=%b wr=%b addr=%h",
                     cyc, mem_read, mem_write, mem_addr, m_rd, m_wr, m_addr);
         end
         total++;
         if (i_ready !== (m_owner == 1 && mem_ready) || d_ready !== (m_owner == 2 && mem_ready)) begin
            bad++;
            $display("FAIL rnd_ready[%0d]: got ir=%b dr=%b expected owner=%0d mem_ready=%b",
                     cyc, i_ready, d_ready, m_owner, mem_ready);
         end
         total++;
         if ((i_ready && i_rdata !== line_of(m_addr)) || (d_ready && d_rdata !== line_of(m_addr))) begin
            bad++;
            $display("FAIL rnd_rdata[%0d]: got i=%h d=%h expected %h", cyc, i_rdata, d_rdata, line_of(m_addr));
         end
         total++;
         if (stat_conflict !== 16'(m_conf) || stat_wait !== 16'(m_wait)) begin
            bad++;
            $display("FAIL rnd_stats[%0d]: got conflict=%0d wait=%0d expected %0d %0d",
                     cyc, stat_conflict, stat_wait, m_conf, m_wait);
         end
         if (i_ready) i_done = 1;
         if (d_ready) d_done = 1;
      end
      do_reset(1);
   endtask

   task automatic test_saturate;
      mem_en = 1'b0;
      @(negedge clk);
      i_read = 1; i_addr = 28'h0000100;
      d_read = 1; d_addr = 28'h0000200;
      for (int c = 0; c < 70000 && stat_wait !== 16'hFFFE; c++) @(negedge clk);
      #3;
      total++;
      if (stat_wait !== 16'hFFFE || m_wait != 65534) begin
         bad++;
         $display("FAIL t6_reach: got wait=%0d model=%0d expected 65534", stat_wait, m_wait);
      end
      repeat (3) @(negedge clk);
      #3;
      total++;
      if (stat_wait !== 16'hFFFF) begin
         bad++;
         $display("FAIL t6_saturate: got wait=%h expected ffff", stat_wait);
      end
      total++;
      if (stat_conflict !== 16'(m_conf)) begin
         bad++;
         $display("FAIL t6_conflict: got %0d expected %0d", stat_conflict, m_conf);
      end
      mem_en = 1'b1;
      do_reset(1);
   endtask

   initial begin
      test_reset;
      test_single_read;
      test_conflict;
      test_alternate;
      test_writeback_refill;
      test_drop;
      test_idle_ready;
      test_reset_mid;
      test_random;
      test_saturate;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
